// File: rtl/spram_fifo_ctrl.sv
// Stream FIFO built on one external single-port synchronous RAM plus a registered
// output word; RAM reads take priority over writes, so at most one access per cycle.
module spram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH:0]   count
);
    // Handshake: a word moves on a side only in a cycle where valid && ready are both 1
    // at the rising edge; in_ready depends on registered state and rst only.

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  rd_pending;
    logic                  rd_req;
    logic                  wr_fire;

    // A read is only launched when the output register and the read pipe are both free,
    // so the returning word always has a place to land.
    assign rd_req    = (ram_cnt != '0) && !out_valid && !rd_pending;
    assign in_ready  = !rst && (ram_cnt != CNT_FULL) && !rd_req;
    assign wr_fire   = in_valid && in_ready;

    assign ram_re    = rd_req && !rst;
    assign ram_we    = wr_fire;
    assign ram_addr  = ram_re ? rd_ptr : wr_ptr;
    assign ram_wdata = in_data;

    assign count = ram_cnt
                 + (ADDR_WIDTH + 1)'(rd_pending)
                 + (ADDR_WIDTH + 1)'(out_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            rd_pending <= rd_req;
            if (rd_req) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                ram_cnt <= ram_cnt - CNT_ONE;
            end else if (wr_fire) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                ram_cnt <= ram_cnt + CNT_ONE;
            end
            // rd_pending implies out_valid is 0, so loading never overwrites a held word.
            if (rd_pending) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl with a behavioural single-port RAM; accepted words are
// queued as expectations and compared against every output handshake.
module tb_spram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;
    int out_total = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[16];
    logic [AW-1:0] exp_wa = '0;
    logic [AW-1:0] exp_ra = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    spram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .count     (count)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard / protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        check("arb_excl", 32'(ram_we && ram_re), 32'd0);
        if (rst) begin
            check("rst_we", 32'(ram_we), 32'd0);
            check("rst_re", 32'(ram_re), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            exp_q.delete();
            exp_wa = '0;
            exp_ra = '0;
            prev_stall = 1'b0;
        end else begin
            if (ram_re) begin
                check("re_blocks_in", 32'(in_ready), 32'd0);
                check("rd_addr", 32'(ram_addr), 32'(exp_ra));
                exp_ra = exp_ra + 1'b1;
            end
            if (ram_we) begin
                check("wr_addr", 32'(ram_addr), 32'(exp_wa));
                exp_wa = exp_wa + 1'b1;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                out_total++;
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 hold out_ready low, 1 high, 2 toggle, 3 random
    task automatic send_stream(input int n, input logic [DW-1:0] base, input int mode);
        int sent = 0;
        int cyc = 0;
        in_valid = 1'b1;
        in_data  = base;
        while (sent < n && cyc < 2000) begin
            @(negedge clk);
            if (in_ready) sent++;
            next_cycle();
            in_data  = base + DW'(sent);
            in_valid = (sent < n);
            case (mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int cyc = 0;
        out_ready = 1'b1;
        while (count != '0 && cyc < 500) begin
            next_cycle();
            cyc++;
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int base_total;
        int cyc;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        // single word latency
        out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check("single_in_ready", 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_re", 32'(ram_re), 32'd1);
        check("single_re_addr", 32'(ram_addr), 32'd0);
        check("single_ov_n1", 32'(out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("single_ov_n2", 32'(out_valid), 32'd0);
        check("single_count_n2", 32'(count), 32'd1);
        next_cycle();
        @(negedge clk);
        check("single_ov_n3", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_count_n3", 32'(count), 32'd1);
        next_cycle();
        @(negedge clk);
        check("single_count_after", 32'(count), 32'd0);
        check("single_ov_after", 32'(out_valid), 32'd0);

        // fill to capacity with no downstream acceptance
        next_cycle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        in_data = '0;
        repeat (40) begin
            @(negedge clk);
            if (in_ready) acc++;
            next_cycle();
            in_data = DW'(acc);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("fill_accepted", 32'(acc), 32'd17);
        check("fill_count", 32'(count), 32'd17);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_out_valid", 32'(out_valid), 32'd1);
        check("fill_out_data", 32'(out_data), 32'h00);
        drain();

        // 40-word stream: both pointers wrap twice
        base_total = out_total;
        send_stream(40, 8'h00, 1);
        drain();
        check("wrap_words_out", 32'(out_total - base_total), 32'd40);

        // toggled backpressure
        base_total = out_total;
        send_stream(20, 8'h80, 2);
        drain();
        check("bp_words_out", 32'(out_total - base_total), 32'd20);

        // reset while a RAM read is in flight
        next_cycle();
        send_stream(6, 8'h50, 0);
        repeat (4) next_cycle();
        check("pre_rst_count", 32'(count), 32'd6);
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_re", 32'(ram_re), 32'd1);
        next_cycle();
        check("pending_count", 32'(count), 32'd5);
        check("pending_ov", 32'(out_valid), 32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_ov", 32'(out_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle_ov", 32'(out_valid), 32'd0);
            next_cycle();
        end
        send_stream(1, 8'h3C, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            next_cycle();
            cyc++;
        end
        check("post_rst_first", 32'(out_data), 32'h3C);
        check("post_rst_first_valid", 32'(out_valid), 32'd1);
        drain();

        // random backpressure
        base_total = out_total;
        send_stream(30, 8'hC0, 3);
        drain();
        check("rand_words_out", 32'(out_total - base_total), 32'd30);

        repeat (2) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
